// File: rtl/mult_issue.sv
// mult_issue: operand FIFO plus one-at-a-time issue FSM in front of a 4x4 multiplier sequencer.
// Ports: clock/n_rst (async active-low); in_valid/in_ready/in_a/in_b operand push side;
//   a_out/b_out/start/ready/product_in sequencer side; out_valid/out_ready/out_product result side; error.
// Optional MULT_ISSUE_TIMEOUT_EN: bounds WAIT_BUSY+WAIT_DONE to TIMEOUT cycles and sets sticky error.
`timescale 1ns/1ps
module mult_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic       clock,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       start,
  input  logic       ready,
  input  logic [7:0] product_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_product,
  output logic       error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mult_issue: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_issue: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];   // {a, b}
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, tmo_hit;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Popping only from IDLE keeps a single multiplication in flight.
  assign pop      = (state == IDLE) && (count != '0);

  // ---------------- operand FIFO ----------------
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- optional timeout ----------------
`ifdef MULT_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          error_q;

  // Counter equals the number of wait cycles already spent; the cycle that
  // would bring it to TIMEOUT is the last one allowed.
  assign tmo_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                   (tmo_cnt == TW'(TIMEOUT - 1));
  assign error   = error_q;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == ISSUE)
        tmo_cnt <= '0;
      else if ((state == WAIT_BUSY) || (state == WAIT_DONE))
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) error_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign error   = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (count != '0) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tmo_hit) state_nxt = IDLE;
                 else if (!ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tmo_hit) state_nxt = IDLE;
                 else if (ready) state_nxt = HOLD;
      HOLD:      if (out_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start     = (state == ISSUE);
    out_valid = (state == HOLD);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      a_out       <= '0;
      b_out       <= '0;
      out_product <= '0;
    end else begin
      if (pop) {a_out, b_out} <= mem[rd_ptr];
      if ((state == WAIT_DONE) && ready && !tmo_hit) out_product <= product_in;
    end
  end

endmodule

// File: tb/tb_mult_issue.sv
`timescale 1ns/1ps
module tb_mult_issue;

  logic       clock = 1'b0;
  logic       n_rst;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b, a_out, b_out;
  logic       start, ready, out_valid, out_ready, error;
  logic [7:0] product_in, out_product;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_res = 0, n_outv = 0;
  int busy_left = 0;
  logic [7:0] exp_q[$];
  logic [7:0] op_q[$];

  mult_issue #(.DEPTH(4), .TIMEOUT(31)) dut (
    .clock(clock), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a_out(a_out), .b_out(b_out), .start(start),
    .ready(ready), .product_in(product_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sequencer + datapath model: busy for 8 cycles after each start pulse.
  assign product_in = (busy_left == 0) ? ({4'b0, a_out} * {4'b0, b_out}) : 8'hA5;

  always @(negedge clock) begin
    if (!n_rst) busy_left = 0;
    else if (start) busy_left = 8;
    else if (busy_left > 0) busy_left = busy_left - 1;
    ready = (busy_left == 0);
  end

  // Monitor / scoreboard: inputs only change #1 after posedge, so the
  // negedge view is what the DUT sees at the next rising edge.
  always @(negedge clock) begin
    if (n_rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back({4'b0, in_a} * {4'b0, in_b});
        op_q.push_back({in_a, in_b});
      end
      if (start) begin
        n_start++;
        chk("issue_pending", op_q.size() > 0, 1);
        if (op_q.size() > 0) chk("issue_ops", {a_out, b_out}, op_q.pop_front());
      end
      if (out_valid) n_outv++;
      if (out_valid && out_ready) begin
        n_res++;
        chk("result_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("result", out_product, exp_q.pop_front());
      end
    end
  end

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    int k = 0;
    logic ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!ok && k < 200) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock); #1;
      k++;
    end
    if (!ok) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int target, input int budget);
    int k = 0;
    while (n_res < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("wait_res", n_res, target);
    @(posedge clock); #1;
  endtask

  initial begin
    int s0, o0, r0, k;
    n_rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_start", start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clock); #1;

    // Single operation (3,5) with issue latency
    push_pair(4'd3, 4'd5);
    @(negedge clock); chk("start_lat1", start, 0);
    @(negedge clock); chk("start_lat2", start, 1);
    chk("a_out_3", a_out, 3);
    chk("b_out_5", b_out, 5);
    @(posedge clock); #1;
    wait_res(1, 100);
    chk("prod_0f", out_product, 8'h0F);
    chk("single_starts", n_start, 1);
    chk("single_error", error, 0);

    // Max operands
    push_pair(4'd15, 4'd15);
    wait_res(2, 100);
    chk("prod_e1", out_product, 8'hE1);

    // Fill + backpressure + result hold
    out_ready = 1'b0;
    s0 = n_start;
    push_pair(4'd1, 4'd2);
    push_pair(4'd4, 4'd7);
    push_pair(4'd9, 4'd9);
    push_pair(4'd12, 4'd13);
    push_pair(4'd15, 4'd1);
    @(negedge clock);
    chk("full_in_ready", in_ready, 0);
    chk("fill_one_issue", n_start - s0, 1);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clock); k++; end
    chk("hold_reach", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_product", out_product, 8'h02);
    end
    chk("hold_no_start", n_start - s0, 1);
    chk("hold_in_ready", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_res(7, 400);
    chk("drain_starts", n_start - s0, 5);

    // Reset mid-operation with two pairs queued
    push_pair(4'd2, 4'd3);
    push_pair(4'd5, 4'd5);
    push_pair(4'd7, 4'd2);
    k = 0;
    while (ready && k < 50) begin @(negedge clock); k++; end
    chk("busy_seen", ready, 0);
    repeat (3) @(negedge clock);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_product", out_product, 0);
    chk("mid_rst_a", a_out, 0);
    chk("mid_rst_b", b_out, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    op_q.delete();
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
    n_rst = 1'b1;
    s0 = n_start; o0 = n_outv; r0 = n_res;
    repeat (40) @(negedge clock);
    chk("post_rst_no_start", n_start - s0, 0);
    chk("post_rst_no_valid", n_outv - o0, 0);
    chk("post_rst_no_res", n_res - r0, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Queue works again after reset
    @(posedge clock); #1;
    push_pair(4'd6, 4'd11);
    wait_res(r0 + 1, 100);
    chk("post_rst_prod", out_product, 8'h42);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
